encoder_velocity_filter: RTL and testbench

Downstream of the quadrature decoder stage. It consumes the signed per-tick count delta the decoder snapshots every 100 Hz window. It keeps a wrapping absolute position and a moving-average velocity over the last 2^LOG2_DEPTH deltas. Outputs feed the encoder peripheral's register bank for bus readout.

---
 rtl/encoder_velocity_filter.sv | 124 ++++++++++++
 tb/tb_encoder_velocity_filter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_velocity_filter.sv
// Encoder velocity filter: wrapping position accumulator plus 2^LOG2_DEPTH-tap moving-average velocity.
// Optional index-edge position capture is built when ENC_INDEX_CAPTURE_EN is defined.
module encoder_velocity_filter #(
    parameter int unsigned LOG2_DEPTH = 3,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk_12MHz,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_delta,
    input  logic              clear_pos,
    input  logic              index,
    output logic [DATA_W-1:0] position,
    output logic [DATA_W-1:0] velocity,
    output logic              velocity_valid,
    output logic              sample_strobe,
    output logic [DATA_W-1:0] index_position,
    output logic              index_seen
);

    localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
    localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int unsigned FILL_W = LOG2_DEPTH + 1;

    logic [DATA_W-1:0]       ring [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr;
    logic [FILL_W-1:0]       fill;
    logic signed [SUM_W-1:0] sum;
    logic                    s1_valid;

    logic signed [SUM_W-1:0] delta_ext;
    logic signed [SUM_W-1:0] evict_ext;
    logic signed [SUM_W-1:0] sum_shr;
    logic                    buf_full;

    // Sum is widened by LOG2_DEPTH bits so adding depth full-scale deltas cannot overflow.
    assign delta_ext = SUM_W'($signed(sample_delta));
    assign evict_ext = SUM_W'($signed(ring[wr_ptr]));
    assign sum_shr   = sum >>> LOG2_DEPTH;
    assign buf_full  = (fill == FILL_W'(DEPTH));

    // Stage 1: ring buffer, running sum, fill count and position.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            ring     <= '{default: '0};
            wr_ptr   <= '0;
            fill     <= '0;
            sum      <= '0;
            s1_valid <= 1'b0;
            position <= '0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                sum          <= sum + delta_ext - evict_ext;
                ring[wr_ptr] <= sample_delta;
                wr_ptr       <= wr_ptr + 1'b1;
                if (!buf_full) begin
                    fill <= fill + 1'b1;
                end
            end
            // Clear takes effect before the coincident delta is added.
            if (clear_pos) begin
                position <= sample_valid ? sample_delta : '0;
            end else if (sample_valid) begin
                position <= position + sample_delta;
            end
        end
    end

    // Stage 2: velocity divide by arithmetic shift and update strobe.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            velocity       <= '0;
            velocity_valid <= 1'b0;
            sample_strobe  <= 1'b0;
        end else begin
            sample_strobe <= s1_valid;
            if (s1_valid) begin
                velocity <= DATA_W'(sum_shr);
                if (buf_full) begin
                    velocity_valid <= 1'b1;
                end
            end
        end
    end

`ifdef ENC_INDEX_CAPTURE_EN
    logic idx_s0;
    logic idx_s1;
    logic idx_s2;
    logic idx_rise;

    assign idx_rise = idx_s1 && !idx_s2;

    // Two-flop synchronizer plus one edge-detect flop; a capture outranks a clear.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            idx_s0         <= 1'b0;
            idx_s1         <= 1'b0;
            idx_s2         <= 1'b0;
            index_position <= '0;
            index_seen     <= 1'b0;
        end else begin
            idx_s0 <= index;
            idx_s1 <= idx_s0;
            idx_s2 <= idx_s1;
            if (idx_rise) begin
                index_position <= position;
                index_seen     <= 1'b1;
            end else if (clear_pos) begin
                index_position <= '0;
                index_seen     <= 1'b0;
            end
        end
    end
`else
    logic unused_index;

    assign unused_index   = index;
    assign index_position = '0;
    assign index_seen     = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_velocity_filter.sv
// Directed self-checking bench for encoder_velocity_filter (LOG2_DEPTH=3, DATA_W=32).
module tb_encoder_velocity_filter;

    logic        clk_12MHz;
    logic        reset;
    logic        sample_valid;
    logic [31:0] sample_delta;
    logic        clear_pos;
    logic        index;
    logic [31:0] position;
    logic [31:0] velocity;
    logic        velocity_valid;
    logic        sample_strobe;
    logic [31:0] index_position;
    logic        index_seen;

    int n_checks = 0;
    int n_bad    = 0;

`ifdef ENC_INDEX_CAPTURE_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    encoder_velocity_filter #(
        .LOG2_DEPTH(3),
        .DATA_W    (32)
    ) dut (
        .clk_12MHz     (clk_12MHz),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_delta  (sample_delta),
        .clear_pos     (clear_pos),
        .index         (index),
        .position      (position),
        .velocity      (velocity),
        .velocity_valid(velocity_valid),
        .sample_strobe (sample_strobe),
        .index_position(index_position),
        .index_seen    (index_seen)
    );

    initial clk_12MHz = 1'b0;
    always #5 clk_12MHz = ~clk_12MHz;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_12MHz);
        reset = 1'b1;
        repeat (2) @(negedge clk_12MHz);
        reset = 1'b0;
    endtask

    // Drives one sample pulse; returns at the falling edge after the capturing edge.
    task automatic send(input logic [31:0] d, input logic clr);
        @(negedge clk_12MHz);
        sample_valid = 1'b1;
        sample_delta = d;
        clear_pos    = clr;
        @(negedge clk_12MHz);
        sample_valid = 1'b0;
        clear_pos    = 1'b0;
    endtask

    // One spaced sample (5 cycles) with position, strobe, velocity and valid checks.
    task automatic step(input string tag, input logic [31:0] d, input logic [31:0] ep,
                        input logic [31:0] ev, input logic evv);
        send(d, 1'b0);
        check_val({tag, ".pos"}, position, ep);
        check_val({tag, ".stb_early"}, 32'(sample_strobe), 32'd0);
        @(negedge clk_12MHz);
        check_val({tag, ".stb"}, 32'(sample_strobe), 32'd1);
        check_val({tag, ".vel"}, velocity, ev);
        check_val({tag, ".vv"}, 32'(velocity_valid), 32'(evv));
        @(negedge clk_12MHz);
        check_val({tag, ".stb_off"}, 32'(sample_strobe), 32'd0);
        repeat (2) @(negedge clk_12MHz);
    endtask

    int neg_vel [8] = '{13, 10, 7, 4, 1, -2, -5, -8};

    logic [31:0] bd   [2][4] = '{'{1, 2, 3, 4}, '{8, 16, 24, 32}};
    logic [31:0] bpos [2][6] = '{'{1, 3, 6, 10, 10, 10}, '{18, 34, 58, 90, 90, 90}};
    logic [31:0] bvel [2][6] = '{'{0, 0, 0, 0, 1, 1}, '{1, 2, 4, 7, 11, 11}};
    logic        bstb [6]    = '{0, 1, 1, 1, 1, 0};
    logic        bvv  [2][6] = '{'{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1, 1}};

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_delta = '0;
        clear_pos    = 1'b0;
        index        = 1'b0;
        do_reset();

        check_val("rst.pos", position, 32'd0);
        check_val("rst.vel", velocity, 32'd0);
        check_val("rst.vv", 32'(velocity_valid), 32'd0);
        check_val("rst.stb", 32'(sample_strobe), 32'd0);
        check_val("rst.ipos", index_position, 32'd0);
        check_val("rst.iseen", 32'(index_seen), 32'd0);

        // Fill with +16: velocity climbs 2,4,...,16; valid rises with the 8th strobe.
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("up%0d", k), 32'd16, 32'(16 * k), 32'(2 * k), k == 8);
        end
        // Replace with -8: sum drains 104..-64, velocity rounds toward -inf.
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("dn%0d", k), 32'hFFFF_FFF8, 32'(128 - 8 * k), 32'(neg_vel[k-1]), 1'b1);
        end

        // Partial sum -4 divides to -1.
        do_reset();
        step("rnd", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);

        // Position wraps without saturation; the widened sum stays positive.
        do_reset();
        step("wrap_a", 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h0FFF_FFFE, 1'b0);
        step("wrap_b", 32'h0000_0020, 32'h8000_0010, 32'h1000_0002, 1'b0);

        // Back-to-back bursts of four samples.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk_12MHz);
            sample_valid = 1'b1;
            sample_delta = bd[b][0];
            for (int c = 0; c < 6; c++) begin
                @(negedge clk_12MHz);
                if (c < 3) sample_delta = bd[b][c+1];
                else       sample_valid = 1'b0;
                check_val($sformatf("b2b%0d.pos%0d", b, c), position, bpos[b][c]);
                check_val($sformatf("b2b%0d.stb%0d", b, c), 32'(sample_strobe), 32'(bstb[c]));
                check_val($sformatf("b2b%0d.vel%0d", b, c), velocity, bvel[b][c]);
                check_val($sformatf("b2b%0d.vv%0d", b, c), 32'(velocity_valid), 32'(bvv[b][c]));
            end
            repeat (2) @(negedge clk_12MHz);
        end

        // Clear coincident with a sample: position = delta, averaging untouched.
        do_reset();
        step("pre_clr", 32'd1000, 32'd1000, 32'd125, 1'b0);
        send(32'd5, 1'b1);
        check_val("clr_add.pos", position, 32'd5);
        @(negedge clk_12MHz);
        check_val("clr_add.stb", 32'(sample_strobe), 32'd1);
        check_val("clr_add.vel", velocity, 32'd125);
        @(negedge clk_12MHz);
        clear_pos = 1'b1;
        @(negedge clk_12MHz);
        clear_pos = 1'b0;
        check_val("clr_only.pos", position, 32'd0);
        check_val("clr_only.vel", velocity, 32'd125);
        check_val("clr_only.stb", 32'(sample_strobe), 32'd0);

        // Index capture: three edges from the transition, then cleared.
        do_reset();
        step("pre_idx", 32'd300, 32'd300, 32'd37, 1'b0);
        index = 1'b1;
        @(negedge clk_12MHz);
        check_val("idx.seen_e0", 32'(index_seen), 32'd0);
        @(negedge clk_12MHz);
        check_val("idx.seen_e1", 32'(index_seen), 32'd0);
        @(negedge clk_12MHz);
        check_val("idx.seen_e2", 32'(index_seen), 32'(IDX_EN));
        check_val("idx.pos_e2", index_position, IDX_EN ? 32'd300 : 32'd0);
        step("post_idx", 32'd50, 32'd350, 32'd43, 1'b0);
        check_val("idx.hold", index_position, IDX_EN ? 32'd300 : 32'd0);
        @(negedge clk_12MHz);
        clear_pos = 1'b1;
        @(negedge clk_12MHz);
        clear_pos = 1'b0;
        check_val("idx_clr.ipos", index_position, 32'd0);
        check_val("idx_clr.seen", 32'(index_seen), 32'd0);
        check_val("idx_clr.pos", position, 32'd0);
        index = 1'b0;

        // Reset arriving while a sample sits in stage 1 suppresses its strobe.
        do_reset();
        @(negedge clk_12MHz);
        sample_valid = 1'b1;
        sample_delta = 32'd64;
        @(negedge clk_12MHz);
        sample_valid = 1'b0;
        reset        = 1'b1;
        check_val("midrst.pos", position, 32'd64);
        @(negedge clk_12MHz);
        reset = 1'b0;
        check_val("midrst.stb", 32'(sample_strobe), 32'd0);
        check_val("midrst.pos0", position, 32'd0);
        @(negedge clk_12MHz);
        check_val("midrst.stb_after", 32'(sample_strobe), 32'd0);
        check_val("midrst.vel", velocity, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
